// File: rtl/pid_trigger_scaler.sv
`default_nettype none
// ============================================================================
// pid_trigger_scaler : masked per-species PID OR, prescale, deadtime trigger
//                      FSM and saturating rate scalers on a local bus.
// Optional: PID_TRIG_PILEUP_EN adds a pileup scaler at offset 13.
// Revision: 1.0
// ============================================================================
module pid_trigger_scaler #(
  parameter int         NCH      = 16,
  parameter logic [7:0] BASE     = 8'hC0,
  parameter logic [7:0] DEADTIME = 8'd10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] Electron,
  input  logic [NCH-1:0] Pion,
  input  logic [NCH-1:0] Muon,
  output logic           TrigOut,
  output logic [2:0]     TrigType,
  output logic           Busy,
  output logic [31:0]    DataOut,
  input  logic [31:0]    DataIn,
  input  logic [7:0]     Address,
  input  logic           Read,
  input  logic           Write
);

  typedef enum logic [1:0] {IDLE = 2'd0, FIRE = 2'd1, DEAD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [NCH-1:0]   ein_q, pin_q, min_q;
  logic [2:0]       hit_q, hit_d, pass;
  logic [2:0]       en_q, en_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [15:0]      pre_q [3];
  logic [15:0]      pre_d [3];
  logic [15:0]      pcnt_q [3];
  logic [15:0]      pcnt_d [3];
  logic [7:0]       dead_q, dead_d, dcnt_q, dcnt_d;
  logic [2:0]       type_q, type_d;
  logic [31:0]      raw_e_q, raw_p_q, raw_m_q, trig_cnt_q;
  logic [31:0]      raw_e_d, raw_p_d, raw_m_d, trig_cnt_d;
  logic [31:0]      sh_e_q, sh_p_q, sh_m_q, sh_t_q;
  logic [31:0]      sh_e_d, sh_p_d, sh_m_d, sh_t_d;
  logic             sel, wr, clr, lat;
  logic [3:0]       off;
  logic             unused_din;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
  endfunction

  assign sel        = (Address[7:4] == BASE[7:4]);
  assign off        = Address[3:0];
  assign wr         = Write && sel;
  assign clr        = wr && (off == 4'd0) && DataIn[4];
  assign lat        = wr && (off == 4'd0) && DataIn[5];
  assign unused_din = ^DataIn;

  assign TrigOut  = (state_q == FIRE);
  assign TrigType = TrigOut ? type_q : 3'b000;
  assign Busy     = (state_q != IDLE);

  // Register file writes; a prescale write also rearms its counter so the next hit passes.
  always_comb begin
    en_d   = en_q;
    mask_d = mask_q;
    dead_d = dead_q;
    for (int s = 0; s < 3; s++) pre_d[s] = pre_q[s];
    if (wr) begin
      case (off)
        4'd0:    en_d   = DataIn[2:0];
        4'd1:    mask_d = DataIn[NCH-1:0];
        4'd2:    pre_d[0] = DataIn[15:0];
        4'd3:    pre_d[1] = DataIn[15:0];
        4'd4:    pre_d[2] = DataIn[15:0];
        4'd5:    dead_d = DataIn[7:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    hit_d[0] = (|(ein_q & mask_q)) & en_q[0];
    hit_d[1] = (|(pin_q & mask_q)) & en_q[1];
    hit_d[2] = (|(min_q & mask_q)) & en_q[2];
    for (int s = 0; s < 3; s++) begin
      pass[s]   = (state_q == IDLE) && hit_q[s] && (pcnt_q[s] == 16'd0);
      pcnt_d[s] = pcnt_q[s];
      if (wr && off == 4'(s + 2))
        pcnt_d[s] = 16'd0;
      else if (state_q == IDLE && hit_q[s])
        pcnt_d[s] = (pcnt_q[s] == 16'd0) ? pre_q[s] : pcnt_q[s] - 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    type_d  = type_q;
    case (state_q)
      IDLE: if (|pass) begin
        state_d = FIRE;
        type_d  = pass;
      end
      FIRE: if (dead_q == 8'd0) begin
        state_d = IDLE;
      end else begin
        dcnt_d  = dead_q;
        state_d = DEAD;
      end
      DEAD: begin
        dcnt_d = dcnt_q - 8'd1;
        if (dcnt_q <= 8'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear dominates both increment and latch.
  always_comb begin
    raw_e_d    = clr ? 32'd0 : sat_inc(raw_e_q, hit_q[0]);
    raw_p_d    = clr ? 32'd0 : sat_inc(raw_p_q, hit_q[1]);
    raw_m_d    = clr ? 32'd0 : sat_inc(raw_m_q, hit_q[2]);
    trig_cnt_d = clr ? 32'd0 : sat_inc(trig_cnt_q, state_q == FIRE);
    sh_e_d     = clr ? 32'd0 : (lat ? raw_e_q    : sh_e_q);
    sh_p_d     = clr ? 32'd0 : (lat ? raw_p_q    : sh_p_q);
    sh_m_d     = clr ? 32'd0 : (lat ? raw_m_q    : sh_m_q);
    sh_t_d     = clr ? 32'd0 : (lat ? trig_cnt_q : sh_t_q);
  end

`ifdef PID_TRIG_PILEUP_EN
  logic [31:0] pile_q, pile_d, sh_pile_q, sh_pile_d;
  always_comb begin
    pile_d    = clr ? 32'd0 : sat_inc(pile_q, (state_q != IDLE) && (|hit_q));
    sh_pile_d = clr ? 32'd0 : (lat ? pile_q : sh_pile_q);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pile_q    <= 32'd0;
      sh_pile_q <= 32'd0;
    end else begin
      pile_q    <= pile_d;
      sh_pile_q <= sh_pile_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      ein_q      <= '0;
      pin_q      <= '0;
      min_q      <= '0;
      hit_q      <= 3'b000;
      en_q       <= 3'b111;
      mask_q     <= '1;
      dead_q     <= DEADTIME;
      dcnt_q     <= 8'd0;
      type_q     <= 3'b000;
      raw_e_q    <= 32'd0;
      raw_p_q    <= 32'd0;
      raw_m_q    <= 32'd0;
      trig_cnt_q <= 32'd0;
      sh_e_q     <= 32'd0;
      sh_p_q     <= 32'd0;
      sh_m_q     <= 32'd0;
      sh_t_q     <= 32'd0;
      for (int s = 0; s < 3; s++) begin
        pre_q[s]  <= 16'd0;
        pcnt_q[s] <= 16'd0;
      end
    end else begin
      state_q    <= state_d;
      ein_q      <= Electron;
      pin_q      <= Pion;
      min_q      <= Muon;
      hit_q      <= hit_d;
      en_q       <= en_d;
      mask_q     <= mask_d;
      dead_q     <= dead_d;
      dcnt_q     <= dcnt_d;
      type_q     <= type_d;
      raw_e_q    <= raw_e_d;
      raw_p_q    <= raw_p_d;
      raw_m_q    <= raw_m_d;
      trig_cnt_q <= trig_cnt_d;
      sh_e_q     <= sh_e_d;
      sh_p_q     <= sh_p_d;
      sh_m_q     <= sh_m_d;
      sh_t_q     <= sh_t_d;
      for (int s = 0; s < 3; s++) begin
        pre_q[s]  <= pre_d[s];
        pcnt_q[s] <= pcnt_d[s];
      end
    end
  end

  always_comb begin
    DataOut = 32'd0;
    if (Read && sel) begin
      case (off)
        4'd0:  DataOut[2:0]     = en_q;
        4'd1:  DataOut[NCH-1:0] = mask_q;
        4'd2:  DataOut[15:0]    = pre_q[0];
        4'd3:  DataOut[15:0]    = pre_q[1];
        4'd4:  DataOut[15:0]    = pre_q[2];
        4'd5:  DataOut[7:0]     = dead_q;
        4'd8:  DataOut          = sh_e_q;
        4'd9:  DataOut          = sh_p_q;
        4'd10: DataOut          = sh_m_q;
        4'd11: DataOut          = sh_t_q;
        4'd12: DataOut[3:0]     = {type_q, Busy};
`ifdef PID_TRIG_PILEUP_EN
        4'd13: DataOut          = sh_pile_q;
`endif
        default: DataOut = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pid_trigger_scaler.sv
`default_nettype none
// tb_pid_trigger_scaler : scoreboard bench; expected triggers (cycle, species)
// are queued when hits are driven and popped by a TrigOut monitor.
module tb_pid_trigger_scaler;
  localparam int NCH = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [NCH-1:0] Electron = '0, Pion = '0, Muon = '0;
  logic           TrigOut, Busy;
  logic [2:0]     TrigType;
  logic [31:0]    DataOut;
  logic [31:0]    DataIn = '0;
  logic [7:0]     Address = '0;
  logic           Read = 1'b0, Write = 1'b0;

  pid_trigger_scaler #(.NCH(NCH), .BASE(8'hC0), .DEADTIME(8'd10)) dut (
    .clk(clk), .rst(rst), .Electron(Electron), .Pion(Pion), .Muon(Muon),
    .TrigOut(TrigOut), .TrigType(TrigType), .Busy(Busy), .DataOut(DataOut),
    .DataIn(DataIn), .Address(Address), .Read(Read), .Write(Write)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [2:0] typ; } trig_t;
  trig_t       trig_q[$];
  logic [31:0] rd_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every TrigOut pulse must match the oldest queued expectation.
  initial begin
    trig_t t;
    forever begin
      @(negedge clk);
      if (TrigOut === 1'b1) begin
        if (trig_q.size() == 0) begin
          check_val("trig_unexpected", trig_q.size(), 1);
        end else begin
          t = trig_q.pop_front();
          check_val("trig_cycle", cyc, t.cyc);
          check_val("trig_type", {29'd0, TrigType}, {29'd0, t.typ});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic bus_write(input logic [3:0] off, input logic [31:0] d);
    Address = {4'hC, off};
    DataIn  = d;
    Write   = 1'b1;
    idle(1);
    Write   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] off, input logic [31:0] exp);
    rd_q.push_back(exp);
    Address = {4'hC, off};
    Read    = 1'b1;
    #1;
    check_val(tag, DataOut, rd_q.pop_front());
    Read    = 1'b0;
  endtask

  // One-cycle hit on species sp (0=E,1=P,2=M); queue a trigger 3 edges later if it should fire.
  task automatic pulse(input int sp, input int ch, input bit fires);
    logic [NCH-1:0] v;
    trig_t t;
    v = '0;
    v[ch] = 1'b1;
    case (sp)
      0:       Electron = v;
      1:       Pion     = v;
      default: Muon     = v;
    endcase
    if (fires) begin
      t.cyc = cyc + 3;
      t.typ = 3'(1 << sp);
      trig_q.push_back(t);
    end
    idle(1);
    Electron = '0;
    Pion     = '0;
    Muon     = '0;
  endtask

  initial begin
    int    busy_n;
    trig_t t;

    @(negedge clk);
    repeat (3) begin
      check_val("rst_trigout", {31'd0, TrigOut}, 32'd0);
      check_val("rst_busy", {31'd0, Busy}, 32'd0);
      check_val("rst_trigtype", {29'd0, TrigType}, 32'd0);
      check_val("rst_dataout", DataOut, 32'd0);
      idle(1);
    end
    rst = 1'b1;
    read_chk("dflt_ctrl", 4'd0, 32'h7);
    read_chk("dflt_mask", 4'd1, 32'hFFFF);
    read_chk("dflt_dead", 4'd5, 32'h0A);
    read_chk("dflt_unused", 4'd7, 32'h0);

    pulse(0, 3, 1'b1);
    busy_n = 0;
    repeat (20) begin
      if (Busy) busy_n++;
      idle(1);
    end
    check_val("busy_len", busy_n, 11);
    check_val("type_idle", {29'd0, TrigType}, 32'd0);
    bus_write(4'd0, 32'h27);
    read_chk("single_raw_e", 4'd8, 32'd1);
    read_chk("single_trig", 4'd11, 32'd1);
    read_chk("status", 4'd12, 32'h2);
    read_chk("ctrl_selfclr", 4'd0, 32'h7);

    bus_write(4'd3, 32'd2);
    bus_write(4'd0, 32'h17);
    for (int i = 0; i < 9; i++) begin
      pulse(1, 5, (i % 3) == 0);
      idle(19);
    end
    bus_write(4'd0, 32'h27);
    read_chk("pre_raw_p", 4'd9, 32'd9);
    read_chk("pre_trig", 4'd11, 32'd3);
    read_chk("pre_reg", 4'd3, 32'd2);
    bus_write(4'd3, 32'd0);

    bus_write(4'd5, 32'd5);
    bus_write(4'd0, 32'h17);
    for (int k = 0; k < 6; k++) begin
      t.cyc = cyc + 3 + 7 * k;
      t.typ = 3'b100;
      trig_q.push_back(t);
    end
    Muon = 16'h8000;
    idle(40);
    Muon = '0;
    idle(15);
    bus_write(4'd0, 32'h27);
    read_chk("dead_raw_m", 4'd10, 32'd40);
    read_chk("dead_trig", 4'd11, 32'd6);
`ifdef PID_TRIG_PILEUP_EN
    read_chk("pileup", 4'd13, 32'd34);
`else
    read_chk("pileup_absent", 4'd13, 32'd0);
`endif

    bus_write(4'd1, 32'hFFFE);
    bus_write(4'd0, 32'h17);
    pulse(0, 0, 1'b0);
    idle(10);
    bus_write(4'd0, 32'h27);
    read_chk("mask_raw_e", 4'd8, 32'd0);
    pulse(0, 1, 1'b1);
    idle(10);
    bus_write(4'd0, 32'h27);
    read_chk("mask_other_ch", 4'd8, 32'd1);
    bus_write(4'd1, 32'hFFFF);

    force dut.raw_e_q = 32'hFFFF_FFFE;
    idle(1);
    release dut.raw_e_q;
    for (int i = 0; i < 3; i++) begin
      pulse(0, 2, 1'b1);
      idle(10);
    end
    bus_write(4'd0, 32'h27);
    read_chk("sat_raw_e", 4'd8, 32'hFFFF_FFFF);

    pulse(0, 4, 1'b1);
    idle(1);
    bus_write(4'd0, 32'h17);
    idle(10);
    bus_write(4'd0, 32'h27);
    read_chk("clr_hit_raw_e", 4'd8, 32'd0);
    read_chk("clr_hit_trig", 4'd11, 32'd1);

    pulse(0, 6, 1'b1);
    idle(4);
    rst = 1'b0;
    idle(1);
    check_val("midrst_busy", {31'd0, Busy}, 32'd0);
    check_val("midrst_trigout", {31'd0, TrigOut}, 32'd0);
    rst = 1'b1;
    read_chk("midrst_dead", 4'd5, 32'h0A);
    idle(2);
    pulse(0, 6, 1'b1);
    idle(15);

    check_val("trig_pending", trig_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pid_trigger_scaler.md
# pid_trigger_scaler

Downstream consumer of the per-channel fine-time PID discriminators. Collects the per-channel Electron/Pion/Muon match bits for up to 32 channels and ORs them per species under a channel mask. Applies a per-species prescale and a programmable deadtime, then emits a one-cycle trigger pulse with a species tag. Keeps saturating rate scalers readable over the local bus.

## Interface
Parameters:
- NCH, 16: number of channels (1..32).
- BASE, 8'hC0: local-bus base. Upper 4 address bits must equal BASE[7:4]; Address[3:0] selects the register.
- DEADTIME, 8'd10: reset value of the deadtime register.

Ports:
- clk  in  1  system clock, the 50 MHz PID clock.
- rst  in  1  reset, synchronous, active-low.
- Electron  in  NCH  per-channel electron match, synchronous to clk.
- Pion  in  NCH  per-channel pion match.
- Muon  in  NCH  per-channel muon match.
- TrigOut  out  1  one-cycle trigger pulse.
- TrigType  out  3  {M,P,E} species that fired. Valid only while TrigOut=1, otherwise 0.
- Busy  out  1  high in the FIRE and DEAD states.
- DataOut  out  32  read data. 0 unless Read=1 and the address matches.
- DataIn  in  32  write data.
- Address  in  8  register address.
- Read  in  1  read strobe, combinational decode.
- Write  in  1  write strobe, sampled on clk.

## Operation
Registers (offset: contents, reset value):
- 0 Control, 0x7:
  - bits[2:0]: species enable E/P/M.
  - bit4: scaler clear, self-clearing, reads 0.
  - bit5: scaler latch, self-clearing, reads 0.
- 1 ChMask[NCH-1:0], all ones. Bits above NCH read 0.
- 2/3/4 Prescale E/P/M [15:0], 0.
- 5 Deadtime [7:0], DEADTIME.
- 8/9/10 latched raw count E/P/M.
- 11 latched trigger count.
- 12 Status: bit0 = Busy, bits[3:1] = last TrigType.
- Unused offsets read 0. Writes to read-only offsets are ignored.

Datapath:
- Stage 1 registers the inputs.
- Stage 2 forms the species hit: hitS = |(inS_reg & ChMask) & enableS.
- Raw scalers count hitS every cycle, in every FSM state.
- Prescale counter per species:
  - Decrements on hitS only in IDLE.
  - A hit passes when its counter is 0; the counter then reloads with Prescale.
  - Prescale=0 passes every hit. Prescale=N passes 1 hit in N+1.
  - Writing a Prescale register reloads that counter to 0.

FSM, reset state IDLE:
- IDLE: if any species passes, go to FIRE and latch the pass vector into TrigType.
- FIRE (1 cycle): TrigOut=1 and the trigger counter is incremented.
  - If Deadtime=0, go to IDLE; otherwise load the dead counter with Deadtime and go to DEAD.
- DEAD: decrement the dead counter; at 1, go to IDLE. This gives exactly Deadtime cycles in DEAD.
- Hits in FIRE/DEAD neither trigger nor advance prescale counters.

Scalers:
- 32-bit, saturate at 0xFFFFFFFF.
- Latch copies live values to shadow registers; reads return the shadow.
- Clear zeroes live and shadow in the same cycle. If an increment coincides with clear, clear wins. If latch and clear are written together, clear wins.

Reset:
- Reset mid-operation returns the FSM to IDLE and forces TrigOut=0 the next cycle.
- All counters and scalers go to 0. Registers go to their reset values.

Outputs on reset: TrigOut=0, TrigType=0, Busy=0, DataOut=0.

## Timing
- An input bit high before clk edge n gives TrigOut high during the cycle after edge n+2, a latency of 3 edges.
- Minimum trigger spacing is Deadtime+2 cycles; with Deadtime=0 this is 2 cycles.
- Writes take effect at the next clk edge. A hit arriving on the same edge as a ChMask or Control write uses the old value.
- DataOut is combinational from Address/Read and register contents.

## Configuration
- PID_TRIG_PILEUP_EN defined:
  - Adds a 32-bit saturating pileup scaler at offset 13.
  - It counts cycles in FIRE or DEAD where any enabled species hit is present.
  - It is latched and cleared with the other scalers.
- Not defined: offset 13 reads 0, and no pileup logic is built.

## Test plan
- Reset defaults: after rst=0 then 1, read offsets 0, 1, 5 -> 0x7, 0xFFFF (NCH=16), 0x0A. TrigOut=0 throughout.
- Single electron: Electron[3] pulsed for 1 cycle -> TrigOut high exactly 3 edges later for 1 cycle, TrigType=3'b001, Busy high for 11 cycles. After a latch, offset 8 reads 1 and offset 11 reads 1.
- Prescale: Prescale P=2, 9 isolated pion pulses spaced 20 cycles -> 3 triggers, on pulses 1, 4 and 7. Offset 9 reads 9.
- Deadtime: Deadtime=5, muon high continuously for 40 cycles -> triggers every 7 cycles (6 triggers). Raw M count is 40. With PID_TRIG_PILEUP_EN, offset 13 reads 34.
- Mask and saturation: ChMask=0xFFFE with hit on channel 0 -> no trigger and raw E count 0. Force the E scaler to 0xFFFFFFFF, then add hits -> it holds 0xFFFFFFFF. Clear and hit on the same cycle -> reads 0.
- Mid-operation reset: assert rst while in DEAD -> next cycle Busy=0 and TrigOut=0. The first trigger after release occurs on the first hit.
